pcf8574_lcd_writer: RTL

Upstream command sequencer for the I2C byte master, driving an HD44780 character LCD through a PCF8574 I/O-expander backpack in 4-bit mode. After reset it runs the HD44780 power-up and 4-bit init sequence. It then accepts LCD bytes (command or data) from a valid/ready port. Each byte is split into nibbles, encoded as PCF8574 port bytes with E-strobe pulses, and issued as START/WRITE/STOP commands to the I2C master, with HD44780 execution delays enforced in between.

---
 rtl/pcf8574_lcd_pkg.sv | 60 ++++++
 rtl/pcf8574_lcd_writer_cycle_timer.sv | 29 ++
 rtl/pcf8574_lcd_writer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcf8574_lcd_pkg.sv
// Shared types and constants for the PCF8574/HD44780 LCD writer and the I2C byte master.
package pcf8574_lcd_pkg;

  localparam int unsigned CNT_W = 32;

  // Command kinds understood by the I2C byte master.
  typedef enum logic [1:0] {
    I2C_NONE       = 2'd0,
    I2C_START_ADDR = 2'd1,
    I2C_WRITE      = 2'd2,
    I2C_STOP       = 2'd3
  } i2c_kind_e;

  // PCF8574 port bit positions wired to the HD44780 control pins.
  localparam int unsigned PB_RS = 0;
  localparam int unsigned PB_RW = 1;
  localparam int unsigned PB_E  = 2;
  localparam int unsigned PB_BL = 3;

  // Sequencer FSM states.
  localparam logic [3:0] ST_PWRUP_WAIT = 4'd0;
  localparam logic [3:0] ST_INIT_NIB   = 4'd1;
  localparam logic [3:0] ST_INIT_CMD   = 4'd2;
  localparam logic [3:0] ST_IDLE       = 4'd3;
  localparam logic [3:0] ST_TX_START   = 4'd4;
  localparam logic [3:0] ST_TX_BYTE    = 4'd5;
  localparam logic [3:0] ST_TX_STOP    = 4'd6;
  localparam logic [3:0] ST_WAIT_IDLE  = 4'd7;
  localparam logic [3:0] ST_DELAY      = 4'd8;

  // Which part of the sequence the current transaction belongs to.
  localparam logic [1:0] PH_NIB  = 2'd0;
  localparam logic [1:0] PH_CMD  = 2'd1;
  localparam logic [1:0] PH_USER = 2'd2;

  typedef struct packed {
    logic       long_wait;
    logic [7:0] cmd;
  } init_cmd_t;

  // Power-up nibbles that force the controller into 4-bit mode; entry 0 goes first.
  localparam logic [3:0][3:0] INIT_NIB_ROM = {4'h2, 4'h3, 4'h3, 4'h3};

  // Function set 4-bit/2-line, display on, clear (long wait), entry mode; entry 0 goes first.
  localparam init_cmd_t [3:0] INIT_CMD_ROM = {9'h006, 9'h101, 9'h00C, 9'h028};

  // Build one expander port byte: idx[1] selects the low nibble, idx[0]=0 raises E.
  function automatic logic [7:0] port_byte(input logic [7:0] data, input logic rs,
                                           input logic bl, input logic [1:0] idx);
    logic [7:0] pb;
    pb        = 8'h00;
    pb[7:4]   = idx[1] ? data[3:0] : data[7:4];
    pb[PB_BL] = bl;
    pb[PB_E]  = ~idx[0];
    pb[PB_RW] = 1'b0;
    pb[PB_RS] = rs;
    return pb;
  endfunction

endpackage

// File: rtl/pcf8574_lcd_writer_cycle_timer.sv
// Down-counting delay timer; done_c is high while the count reads zero.
module cycle_timer
  import pcf8574_lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/pcf8574_lcd_writer.sv
// HD44780 4-bit command sequencer that feeds PCF8574 port bytes to an I2C byte master.
module pcf8574_lcd_writer
  import pcf8574_lcd_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR       = 7'h27,
  parameter int unsigned POWERUP_CYCLES = 4_000_000,
  parameter int unsigned INIT_CYCLES    = 500_000,
  parameter int unsigned SHORT_CYCLES   = 5_000,
  parameter int unsigned LONG_CYCLES    = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       backlight,
  output logic       i2c_valid,
  output logic [1:0] i2c_kind,
  output logic [7:0] i2c_data,
  input  logic       i2c_ready,
  input  logic       i2c_nack,
  output logic       init_done,
  output logic       error
);

  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_CYCLES - 1);
  localparam logic [7:0]       ADDR_BYTE  = {I2C_ADDR, 1'b0};

  logic [3:0] state_q, state_n;
  logic [1:0] phase_q, phase_n;
  logic [1:0] idx_q, idx_n;
  logic [1:0] byte_idx_q, byte_idx_n;
  logic       rs_q, rs_n;
  logic [7:0] data_q, data_n;
  logic       nib_only_q, nib_only_n;
  logic       long_q, long_n;
  logic       valid_q, valid_n;
  logic [1:0] kind_q, kind_n;
  logic [7:0] dout_q, dout_n;
  logic       in_ready_q, in_ready_n;
  logic       init_done_q, init_done_n;
  logic       error_q, error_n;
  logic       nack_en_q;

  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             tmr_done_c;

  // Reset preloads the power-up wait so it starts counting on the first cycle out of reset.
  cycle_timer #(
    .RST_VAL (PWRUP_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_PWRUP_WAIT;
      phase_q     <= PH_NIB;
      idx_q       <= 2'd0;
      byte_idx_q  <= 2'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      nib_only_q  <= 1'b0;
      long_q      <= 1'b0;
      valid_q     <= 1'b0;
      kind_q      <= 2'(I2C_NONE);
      dout_q      <= 8'h00;
      in_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      nack_en_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      phase_q     <= phase_n;
      idx_q       <= idx_n;
      byte_idx_q  <= byte_idx_n;
      rs_q        <= rs_n;
      data_q      <= data_n;
      nib_only_q  <= nib_only_n;
      long_q      <= long_n;
      valid_q     <= valid_n;
      kind_q      <= kind_n;
      dout_q      <= dout_n;
      in_ready_q  <= in_ready_n;
      init_done_q <= init_done_n;
      error_q     <= error_n;
      nack_en_q   <= 1'b1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    phase_n     = phase_q;
    idx_n       = idx_q;
    byte_idx_n  = byte_idx_q;
    rs_n        = rs_q;
    data_n      = data_q;
    nib_only_n  = nib_only_q;
    long_n      = long_q;
    valid_n     = valid_q;
    kind_n      = kind_q;
    dout_n      = dout_q;
    in_ready_n  = in_ready_q;
    init_done_n = init_done_q;
    tmr_load_c  = 1'b0;
    tmr_val_c   = '0;
    // A NACK in the first cycle out of reset belongs to the previous life and is dropped.
    error_n     = error_q | (i2c_nack & nack_en_q);

    case (state_q)
      ST_PWRUP_WAIT: begin
        if (tmr_done_c) state_n = ST_INIT_NIB;
      end
      ST_INIT_NIB: begin
        rs_n       = 1'b0;
        data_n     = {INIT_NIB_ROM[idx_q], 4'h0};
        nib_only_n = 1'b1;
        long_n     = 1'b0;
        state_n    = ST_TX_START;
        valid_n    = 1'b1;
        kind_n     = 2'(I2C_START_ADDR);
        dout_n     = ADDR_BYTE;
      end
      ST_INIT_CMD: begin
        rs_n       = 1'b0;
        data_n     = INIT_CMD_ROM[idx_q].cmd;
        long_n     = INIT_CMD_ROM[idx_q].long_wait;
        nib_only_n = 1'b0;
        state_n    = ST_TX_START;
        valid_n    = 1'b1;
        kind_n     = 2'(I2C_START_ADDR);
        dout_n     = ADDR_BYTE;
      end
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          rs_n       = in_rs;
          data_n     = in_data;
          nib_only_n = 1'b0;
          long_n     = !in_rs && (in_data == 8'h01 || in_data == 8'h02);
          in_ready_n = 1'b0;
          state_n    = ST_TX_START;
          valid_n    = 1'b1;
          kind_n     = 2'(I2C_START_ADDR);
          dout_n     = ADDR_BYTE;
        end
      end
      ST_TX_START: begin
        if (i2c_ready) begin
          byte_idx_n = 2'd0;
          state_n    = ST_TX_BYTE;
          kind_n     = 2'(I2C_WRITE);
          dout_n     = port_byte(data_q, rs_q, backlight, 2'd0);
        end
      end
      ST_TX_BYTE: begin
        if (i2c_ready) begin
          if (byte_idx_q == (nib_only_q ? 2'd1 : 2'd3)) begin
            byte_idx_n = 2'd0;
            state_n    = ST_TX_STOP;
            kind_n     = 2'(I2C_STOP);
            dout_n     = 8'h00;
          end else begin
            byte_idx_n = 2'(byte_idx_q + 2'd1);
            dout_n     = port_byte(data_q, rs_q, backlight, 2'(byte_idx_q + 2'd1));
          end
        end
      end
      ST_TX_STOP: begin
        if (i2c_ready) begin
          valid_n = 1'b0;
          kind_n  = 2'(I2C_NONE);
          dout_n  = 8'h00;
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // Master idle again means the stop condition has left the bus.
        if (i2c_ready) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = (phase_q == PH_NIB) ? INIT_LOAD : (long_q ? LONG_LOAD : SHORT_LOAD);
          state_n    = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (tmr_done_c) begin
          case (phase_q)
            PH_NIB: begin
              if (idx_q == 2'd3) begin
                idx_n   = 2'd0;
                phase_n = PH_CMD;
                state_n = ST_INIT_CMD;
              end else begin
                idx_n   = 2'(idx_q + 2'd1);
                state_n = ST_INIT_NIB;
              end
            end
            PH_CMD: begin
              if (idx_q == 2'd3) begin
                idx_n       = 2'd0;
                phase_n     = PH_USER;
                init_done_n = 1'b1;
                in_ready_n  = 1'b1;
                state_n     = ST_IDLE;
              end else begin
                idx_n   = 2'(idx_q + 2'd1);
                state_n = ST_INIT_CMD;
              end
            end
            default: begin
              in_ready_n = 1'b1;
              state_n    = ST_IDLE;
            end
          endcase
        end
      end
      default: state_n = ST_PWRUP_WAIT;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign i2c_valid = valid_q;
  assign i2c_kind  = kind_q;
  assign i2c_data  = dout_q;
  assign init_done = init_done_q;
  assign error     = error_q;

endmodule
